// File: rtl/apu_event_arbiter_pkg.sv
// apu_pkg: shared sound IDs, default sizing and width helpers for the APU event path.
package apu_pkg;

  localparam int SND_EAT   = 0;
  localparam int SND_DIE   = 1;
  localparam int SND_HIT   = 2;
  localparam int SND_SPARE = 3;

  localparam int DEFAULT_NUM_EVENTS     = 4;
  localparam int DEFAULT_HOLDOFF_FRAMES = 8;

  function automatic int calcIdWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calcHoldoffWidth(input int frames);
    return (frames > 0) ? $clog2(frames + 1) : 1;
  endfunction

endpackage

// File: rtl/apu_priority_picker.sv
// apu_priority_picker: combinational winner select over a request vector.
// Fixed lowest-index priority, or round-robin after last_grant_i when APU_EVENT_ROUNDROBIN_EN is defined.
module apu_priority_picker
  import apu_pkg::*;
#(
  parameter  int N  = DEFAULT_NUM_EVENTS,
  localparam int IW = calcIdWidth(N)
) (
`ifdef APU_EVENT_ROUNDROBIN_EN
  input  logic [IW-1:0] last_grant_i,
`endif
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  assign any_o = |req_i;

`ifdef APU_EVENT_ROUNDROBIN_EN
  // Scan starts one past the previous winner and wraps, so every requester is reached within N grants.
  always_comb begin
    int   j;
    logic found;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_grant_i) + k) % N;
      if (!found && req_i[j]) begin
        idx_o = IW'(j);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end
`endif

endmodule

// File: rtl/apu_event_arbiter.sv
// apu_event_arbiter: frame-sampled event edge detector with per-channel holdoff and a valid/ready sound ID output.
// Optional round-robin arbitration via APU_EVENT_ROUNDROBIN_EN (default: fixed lowest-index priority).
module apu_event_arbiter
  import apu_pkg::*;
#(
  parameter  int NUM_EVENTS     = DEFAULT_NUM_EVENTS,
  parameter  int HOLDOFF_FRAMES = DEFAULT_HOLDOFF_FRAMES,
  localparam int ID_W           = calcIdWidth(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_end,
  input  logic                  test_mode,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  sound_ready,
  output logic                  sound_valid,
  output logic [ID_W-1:0]       sound_id,
  output logic [NUM_EVENTS-1:0] pending_o
);

  logic [NUM_EVENTS-1:0] sample_q, sample_d;
  logic [NUM_EVENTS-1:0] pending_q, pending_d;
  logic                  valid_q, valid_d;
  logic [ID_W-1:0]       id_q, id_d;

  logic [NUM_EVENTS-1:0] sampleEdge, edgeMask, grantMask, holdoffClear;
  logic                  outFree, grant, pickAny;
  logic [ID_W-1:0]       pickIdx;

`ifdef APU_EVENT_ROUNDROBIN_EN
  logic [ID_W-1:0] lastGrant_q, lastGrant_d;

  assign lastGrant_d = grant ? pickIdx : lastGrant_q;

  // Reset to the top index so channel 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) lastGrant_q <= ID_W'(NUM_EVENTS - 1);
    else       lastGrant_q <= lastGrant_d;
  end

  apu_priority_picker #(.N(NUM_EVENTS)) uPicker (
    .last_grant_i (lastGrant_q),
    .req_i        (pending_q),
    .idx_o        (pickIdx),
    .any_o        (pickAny)
  );
`else
  apu_priority_picker #(.N(NUM_EVENTS)) uPicker (
    .req_i (pending_q),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );
`endif

  // Grant clears the winner after the edge merge, so an edge landing on the winner in the same cycle is lost.
  always_comb begin
    outFree    = ~valid_q | sound_ready;
    grant      = outFree & pickAny;
    grantMask  = grant ? (NUM_EVENTS'(1) << pickIdx) : '0;
    sampleEdge = event_in & ~sample_q;
    if (test_mode)      edgeMask = sampleEdge;
    else if (frame_end) edgeMask = sampleEdge & holdoffClear;
    else                edgeMask = '0;
    sample_d  = (test_mode | frame_end) ? event_in : sample_q;
    pending_d = (pending_q | edgeMask) & ~grantMask;
    valid_d   = outFree ? pickAny : valid_q;
    id_d      = grant ? pickIdx : id_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q  <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
    end else begin
      sample_q  <= sample_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
    end
  end

  generate
    if (HOLDOFF_FRAMES > 0) begin : gHoldoff
      localparam int HW = calcHoldoffWidth(HOLDOFF_FRAMES);
      logic [HW-1:0] holdoff_q [NUM_EVENTS];

      // The gate reads the pre-decrement count, so a channel reaching zero on this frame_end is still deaf.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_EVENTS; i++) holdoff_q[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_EVENTS; i++) begin
            if (grantMask[i])
              holdoff_q[i] <= HW'(HOLDOFF_FRAMES);
            else if (frame_end && !test_mode && holdoff_q[i] != '0)
              holdoff_q[i] <= holdoff_q[i] - HW'(1);
          end
        end
      end

      always_comb begin
        holdoffClear = '0;
        for (int i = 0; i < NUM_EVENTS; i++) holdoffClear[i] = (holdoff_q[i] == '0);
      end
    end else begin : gNoHoldoff
      assign holdoffClear = '1;
    end
  endgenerate

  assign sound_valid = valid_q;
  assign sound_id    = id_q;
  assign pending_o   = pending_q;

endmodule
